// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH flip-flop register file: two combinational read ports and one clocked write port.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_2r1w #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr1,
   output logic [WIDTH-1:0]         rdata1,
   input  logic [$clog2(DEPTH)-1:0] raddr2,
   output logic [WIDTH-1:0]         rdata2
);

   localparam int AW    = $clog2(DEPTH);
   // Lowest entry that is writable and readable; entry 0 is skipped when it is the zero register.
   localparam int FIRST = (ZERO_REG != 0) ? 1 : 0;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    raddr [2];
   logic [WIDTH-1:0] rdata [2];

   assign raddr[0] = raddr1;
   assign raddr[1] = raddr2;
   assign rdata1   = rdata[0];
   assign rdata2   = rdata[1];

   // Out-of-range addresses match no entry, so writes to them are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int i = FIRST; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
               mem[i] <= wdata;
            end
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      logic hit;
      always_comb begin
         hit      = 1'b0;
         rdata[p] = '0;
         for (int i = FIRST; i < DEPTH; i++) begin
            if (raddr[p] == AW'(i)) begin
               hit      = 1'b1;
               rdata[p] = mem[i];
            end
         end
         // Forward only to addresses that a write could actually land on.
         if (hit && !rst && we && (raddr[p] == waddr)) begin
            rdata[p] = wdata;
         end
      end
`else
      always_comb begin
         rdata[p] = '0;
         for (int i = FIRST; i < DEPTH; i++) begin
            if (raddr[p] == AW'(i)) begin
               rdata[p] = mem[i];
            end
         end
      end
`endif
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench: DUT a (DEPTH=32, ZERO_REG=1) and DUT b (DEPTH=24, ZERO_REG=0) share stimulus;
// each is checked against an array model every cycle, plus directed literal checks.
`timescale 1ns/1ns
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rd_a1, rd_a2, rd_b1, rd_b2;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] model_a [32];
   logic [31:0] model_b [32];

   regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd_a1), .raddr2(raddr2), .rdata2(rd_a2));

   regfile_2r1w #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd_b1), .raddr2(raddr2), .rdata2(rd_b2));

   always #50 clk = ~clk;

   function automatic bit accessible(input bit inst_b, input logic [4:0] a);
      int depth;
      bit zr;
      depth = inst_b ? 24 : 32;
      zr    = inst_b ? 1'b0 : 1'b1;
      return (int'(a) < depth) && !(zr && a == 5'd0);
   endfunction

   function automatic logic [31:0] exp_rd(input bit inst_b, input logic [4:0] a);
      if (!accessible(inst_b, a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (!rst && we && waddr == a) return wdata;
`endif
      return inst_b ? model_b[a] : model_a[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            model_a[i] = 32'h0;
            model_b[i] = 32'h0;
         end
      end else if (we) begin
         if (accessible(1'b0, waddr)) model_a[waddr] = wdata;
         if (accessible(1'b1, waddr)) model_b[waddr] = wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   task automatic chk_all_ports();
      chk("a_rd1", rd_a1, exp_rd(1'b0, raddr1));
      chk("a_rd2", rd_a2, exp_rd(1'b0, raddr2));
      chk("b_rd1", rd_b1, exp_rd(1'b1, raddr1));
      chk("b_rd2", rd_b2, exp_rd(1'b1, raddr2));
   endtask

   always @(negedge clk) chk_all_ports();

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      step();
      we = 1'b1; waddr = a; wdata = d;
      step();
      we = 1'b0;
   endtask

   task automatic sweep_model();
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         #1;
         chk_all_ports();
      end
   endtask

   logic [31:0] pre9;

   initial begin
      rst = 1'b1;
      #20 rst = 1'b0;
      step();
      raddr1 = 5'd0; raddr2 = 5'd31;
      #1;
      chk("reset_a1", rd_a1, 32'h0);
      chk("reset_b2", rd_b2, 32'h0);

      // reset clear, mid-cycle
      for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
      raddr1 = 5'd7; #1;
      chk("preload_a7", rd_a1, 32'hA5A5_0007);
      rst = 1'b1;
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         #1;
         chk("rstclr_a1", rd_a1, 32'h0);
         chk("rstclr_a2", rd_a2, 32'h0);
         chk("rstclr_b1", rd_b1, 32'h0);
         chk("rstclr_b2", rd_b2, 32'h0);
      end
      rst = 1'b0;
      wr(5'd5, 32'h1234);
      raddr1 = 5'd5; #1;
      chk("post_rst_wr5", rd_a1, 32'h1234);
      chk("post_rst_wr5_b", rd_b1, 32'h1234);

      // basic dual-port
      rst = 1'b1; #1 rst = 1'b0;
      wr(5'd3, 32'hDEAD_BEEF);
      wr(5'd31, 32'h0000_00FF);
      raddr1 = 5'd3; raddr2 = 5'd31; #1;
      chk("dual_a1", rd_a1, 32'hDEAD_BEEF);
      chk("dual_a2", rd_a2, 32'h0000_00FF);
      chk("dual_b2_oor", rd_b2, 32'h0);
      for (int a = 0; a < 32; a++) begin
         if (a != 3 && a != 31) begin
            raddr1 = 5'(a); #1;
            chk("others_zero", rd_a1, 32'h0);
         end
      end

      // zero register
      wr(5'd0, 32'hFFFF_FFFF);
      raddr1 = 5'd0; #1;
      chk("zero_reg_a", rd_a1, 32'h0);
      chk("zero_reg_off_b", rd_b1, 32'hFFFF_FFFF);

      // we gating and out-of-range
      wr(5'd7, 32'h99);
      step();
      we = 1'b0; waddr = 5'd7; wdata = 32'h55;
      step();
      raddr1 = 5'd7; #1;
      chk("we_gate_a7", rd_a1, 32'h99);
      wr(5'd27, 32'hABCD);
      raddr1 = 5'd27; #1;
      chk("oor_b27", rd_b1, 32'h0);
      chk("inrange_a27", rd_a1, 32'hABCD);
      sweep_model();

      // same-cycle read-after-write on 9
      wr(5'd9, 32'h11);
      we = 1'b1; waddr = 5'd9; wdata = 32'h22; raddr1 = 5'd9; raddr2 = 5'd0;
      #1;
`ifdef REGFILE_BYPASS_EN
      pre9 = 32'h22;
`else
      pre9 = 32'h11;
`endif
      chk("raw9_before", rd_a1, pre9);
      chk("raw9_r2zero", rd_a2, 32'h0);
      step();
      we = 1'b0; #1;
      chk("raw9_after", rd_a1, 32'h22);
      chk("raw9_r2zero_after", rd_a2, 32'h0);

      // reset / write collision
      wr(5'd4, 32'h44);
      we = 1'b1; waddr = 5'd4; wdata = 32'h77; raddr1 = 5'd4;
      #10 rst = 1'b1;
      step();
      rst = 1'b0; we = 1'b0; #1;
      chk("collision_lost", rd_a1, 32'h0);
      we = 1'b1;
      step();
      we = 1'b0; #1;
      chk("collision_retry", rd_a1, 32'h77);

      // back-to-back writes: each value visible one cycle, last wins
      we = 1'b1; waddr = 5'd12; wdata = 32'h100; raddr1 = 5'd12;
      step(); wdata = 32'h200; #1;
      chk("b2b_first", rd_a1, exp_rd(1'b0, 5'd12));
      step(); we = 1'b0; #1;
      chk("b2b_last", rd_a1, 32'h200);

      // randomized traffic, checked every negedge by the compare process
      for (int n = 0; n < 600; n++) begin
         step();
         we     = 1'($urandom_range(0, 1));
         waddr  = 5'($urandom);
         wdata  = $urandom;
         raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
         raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
         if ($urandom_range(0, 63) == 0) begin
            #5 rst = 1'b1;
            #1;
            chk_all_ports();
            #5 rst = 1'b0;
         end
      end
      step();
      we = 1'b0;
      sweep_model();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised general-purpose register file for the CPU datapath: DEPTH entries of WIDTH bits, two combinational read ports, one clocked write port. It is the flip-flop-based, multi-entry successor to the single-bit level-sensitive D-latch storage element in REGFILE/. It sits between decode (read addresses) and writeback (write port). An optional same-cycle write-to-read bypass is available.

## Interface
- WIDTH, 32: data width of each entry, in bits (>= 1).
- DEPTH, 32: number of entries (>= 2; need not be a power of two).
- ZERO_REG, 1: when 1, entry 0 is hardwired to zero; when 0, entry 0 is an ordinary register.
- AW, $clog2(DEPTH): address width (derived localparam; not overridden).

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock; all writes on rising edge.
- rst  in  1  asynchronous active-high reset; clears every entry.
- we  in  1  write enable, sampled on the rising edge of clk.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr1  in  AW  read port 1 address.
- rdata1  out  WIDTH  read port 1 data, combinational.
- raddr2  in  AW  read port 2 address.
- rdata2  out  WIDTH  read port 2 data, combinational.

## Operation
- Storage: DEPTH x WIDTH flip-flops. No latches anywhere.
- Reset: while rst=1, every entry is 0 immediately, without waiting for a clock edge. Consequently rdata1 = rdata2 = 0 for every address.
- Write: on a rising clk edge with rst=0 and we=1, entry[waddr] <= wdata. The write is ignored in either of these cases:
  - waddr >= DEPTH;
  - ZERO_REG=1 and waddr=0.
- Read: rdataN = entry[raddrN], combinational from the address and stored contents. rdataN = 0 in either of these cases:
  - raddrN >= DEPTH;
  - ZERO_REG=1 and raddrN=0.
- Both read ports are fully independent. raddr1 = raddr2 is legal; both return the same value.
- A write never disturbs any entry other than entry[waddr].
- Bypass behaviour is defined in Configuration.

## Timing
- Write latency: one edge. Without bypass, data written at edge k is visible on the read ports after edge k and stays visible until overwritten.
- Read latency: zero cycles (combinational). Outputs settle within the same cycle as an address change.
- Write and read of the same address in one cycle, without bypass: rdata shows the old value before the edge and the new value after it.
- Reset asserted mid-cycle: contents clear asynchronously. A write whose edge coincides with rst=1 is lost.
- Reset deasserted: the first write takes effect on the first rising edge that samples rst=0.
- Back-to-back writes to the same address on consecutive edges: the last write wins. Each intermediate value is visible for exactly one cycle.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: when we=1 and rst=0 and raddrN equals waddr, and that address is writable (in range, and not 0 when ZERO_REG=1), rdataN = wdata combinationally in the same cycle, before the edge.
  - The bypass never overrides the zero register or an out-of-range address.
  - The bypass applies independently to each read port.
- Undefined: there is no forwarding path; rdataN always reflects stored contents only.

## Test plan
- Reset clear: preload entries 1..31 with 0xA5A5_0000+i, then pulse rst mid-cycle (no clock edge) -> rdata1/rdata2 read 0 for every address immediately; the next write with we=1 to addr 5 of 0x1234 reads back 0x1234 after one edge.
- Basic write/read, dual port: write 0xDEAD_BEEF to addr 3 and 0x0000_00FF to addr 31 -> raddr1=3, raddr2=31 return 0xDEAD_BEEF and 0x0000_00FF; every other entry is still 0.
- Zero register: with ZERO_REG=1, write 0xFFFF_FFFF to addr 0 -> rdata reads 0. With ZERO_REG=0, the same write reads back 0xFFFF_FFFF.
- we gating and out-of-range: we=0 with waddr=7, wdata=0x55 -> entry 7 is unchanged. With DEPTH=24, AW=5, write to addr 27 -> ignored, raddr=27 reads 0, and entries 0..23 are unchanged.
- Same-cycle read-after-write on addr 9 (old value 0x11, wdata 0x22):
  - without REGFILE_BYPASS_EN, rdata1 = 0x11 before the edge and 0x22 after it;
  - with the macro, rdata1 = 0x22 before the edge;
  - in both builds, raddr2=0 stays 0.
- Reset/write collision: we=1, waddr=4, wdata=0x77 with rst rising before the edge -> entry 4 = 0 after the edge. After rst falls, the same write yields 0x77 one edge later.
